// File: rtl/cmd_arbiter.sv
// Merges NREQ game-command requesters into a QSIZE-deep command FIFO with a valid/ready head.
// Define CMD_ARBITER_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module cmd_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned CMD_W  = 4,
    parameter int unsigned QSIZE  = 16,
    parameter int unsigned NONE_C = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*CMD_W-1:0]     req_cmd,
    output logic [NREQ-1:0]           req_grant,
    input  logic                      flush,
    input  logic                      cmd_ready,
    output logic                      cmd_valid,
    output logic [CMD_W-1:0]          cmd,
    output logic [$clog2(QSIZE):0]    count,
    output logic                      full
);

    localparam int unsigned PTR_W = $clog2(QSIZE);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CMD_W-1:0] NONE_CMD = CMD_W'(NONE_C);

    if (QSIZE < 2 || (QSIZE & (QSIZE - 1)) != 0) begin : g_bad_qsize
        $error("cmd_arbiter: QSIZE must be a power of 2 and >= 2");
    end

    logic [CMD_W-1:0] mem [QSIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_inc;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             full_q;
    logic             cmd_valid_q;
    logic [CMD_W-1:0] cmd_q;
    logic [CMD_W-1:0] head_next;

    logic             pop;
    logic             space;
    logic             grant_en;
    logic             req_seen;
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic [CMD_W-1:0] push_cmd;
    logic             push;

    assign pop      = cmd_valid_q & cmd_ready;
    assign space    = ~full_q | pop;
    assign grant_en = reset_n & space & ~flush;

`ifdef CMD_ARBITER_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // Rotating start index; only advances on an actual grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end
`endif

    // Pick the first eligible requester in search order.
    always_comb begin
        req_seen  = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
`ifdef CMD_ARBITER_RR_EN
            cand = IDX_W'((32'(rr_ptr) + off) % NREQ);
`else
            cand = IDX_W'(off);
`endif
            if (!req_seen && req_valid[cand]) begin
                req_seen  = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_any = req_seen & grant_en;
    assign req_grant = grant_any ? (NREQ'(1) << grant_idx) : '0;
    assign push_cmd  = req_cmd[32'(grant_idx) * CMD_W +: CMD_W];
    assign push      = grant_any & (push_cmd != NONE_CMD);
    assign rd_inc    = rd_ptr + PTR_W'(1);

    // Next occupancy and next head; the head register never bypasses a same-cycle push.
    always_comb begin
        cnt_next  = cnt_q;
        head_next = cmd_q;
        if (push && !pop) begin
            cnt_next = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_next = cnt_q - CNT_W'(1);
        end
        if (pop) begin
            head_next = (cnt_q > CNT_W'(1)) ? mem[rd_inc] : push_cmd;
        end else if (cnt_q == '0) begin
            head_next = push_cmd;
        end
        if (flush) begin
            cnt_next = '0;
        end
        if (cnt_next == '0) begin
            head_next = NONE_CMD;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= NONE_CMD;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_inc;
                end
            end
            cnt_q       <= cnt_next;
            full_q      <= (cnt_next == CNT_W'(QSIZE));
            cmd_valid_q <= (cnt_next != '0);
            cmd_q       <= head_next;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign count     = cnt_q;
    assign full      = full_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_cmd_arbiter;

    localparam int NREQ  = 4;
    localparam int CMD_W = 4;
    localparam int QSIZE = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [15:0] req_cmd;
    logic [3:0]  req_grant;
    logic        flush;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [4:0]  count;
    logic        full;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned mq[$];
    int          m_rr;

    cmd_arbiter #(.NREQ(NREQ), .CMD_W(CMD_W), .QSIZE(QSIZE), .NONE_C(0)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_grant(req_grant), .flush(flush), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd(cmd), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [3:0] v);
        for (int off = 0; off < NREQ; off++) begin
`ifdef CMD_ARBITER_RR_EN
            int k = (m_rr + off) % NREQ;
`else
            int k = off;
`endif
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_grant();
        int  k;
        bit  pop;
        if (!reset_n || flush) return 4'b0;
        pop = (mq.size() > 0) && cmd_ready;
        if (mq.size() == QSIZE && !pop) return 4'b0;
        k = model_pick(req_valid);
        if (k < 0) return 4'b0;
        return 4'(1 << k);
    endfunction

    // One clock: compute the model's view of this cycle, clock the DUT, then update the model.
    task automatic advance();
        logic [3:0]  g;
        logic [15:0] cmds;
        bit          pop;
        bit          rst_at_edge;
        g    = model_grant();
        cmds = req_cmd;
        pop  = (mq.size() > 0) && cmd_ready && reset_n && !flush;
        @(posedge clk);
        rst_at_edge = !reset_n;
        #1;
        if (rst_at_edge) begin
            mq.delete();
            m_rr = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            for (int k = 0; k < NREQ; k++) begin
                if (g[k]) begin
                    if (cmds[k*4 +: 4] != 4'd0) mq.push_back(int'(cmds[k*4 +: 4]));
                    m_rr = (k + 1) % NREQ;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        flush     = 1'b0;
        cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        m_rr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        req_valid = 4'b0001;
        req_cmd   = 16'h0009;
        repeat (3) advance();
        #2;
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_cmd   = 16'h4321;
        #1;
        n_checks++; if (req_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", req_grant); end
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
        n_checks++; if (cmd !== 4'd0) begin n_fail++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req_cmd   = {4'd7, 4'd0, 4'd5, 4'd0};
        req_valid = 4'b1010;
        #1;
        n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL prio_first: got %b expected 0010", req_grant); end
        advance();
        req_valid = 4'b1000;
        #1;
        n_checks++; if (req_grant !== 4'b1000) begin n_fail++; $display("FAIL prio_second: got %b expected 1000", req_grant); end
        advance();
        req_valid = 4'b0000;
        n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL prio_count: got %0d expected 2", count); end
        n_checks++; if (cmd !== 4'd5 || cmd_valid !== 1'b1) begin n_fail++; $display("FAIL prio_head0: got %0d/%b expected 5/1", cmd, cmd_valid); end
        cmd_ready = 1'b1;
        advance();
        n_checks++; if (cmd !== 4'd7) begin n_fail++; $display("FAIL prio_head1: got %0d expected 7", cmd); end
        advance();
        n_checks++; if (cmd_valid !== 1'b0 || cmd !== 4'd0 || count !== 5'd0) begin
            n_fail++; $display("FAIL prio_drain: got valid=%b cmd=%0d count=%0d expected 0/0/0", cmd_valid, cmd, count);
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        req_valid = 4'b0001;
        req_cmd   = 16'h0002;
        for (int i = 0; i < QSIZE; i++) begin
            #1;
            n_checks++; if (req_grant !== 4'b0001) begin n_fail++; $display("FAIL fill_grant[%0d]: got %b expected 0001", i, req_grant); end
            advance();
        end
        n_checks++; if (count !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got count=%0d full=%b expected 16/1", count, full); end
        #1;
        n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL fill_blocked: got %b expected 0000", req_grant); end
        advance();
        cmd_ready = 1'b1;
        #1;
        n_checks++; if (req_grant !== 4'b0001) begin n_fail++; $display("FAIL fill_pop_push: got %b expected 0001", req_grant); end
        advance();
        cmd_ready = 1'b0;
        req_valid = 4'b0000;
        n_checks++; if (count !== 5'd16 || full !== 1'b1 || cmd !== 4'd2) begin
            n_fail++; $display("FAIL fill_after: got count=%0d full=%b cmd=%0d expected 16/1/2", count, full, cmd);
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b0100;
        req_cmd   = 16'h0300;
        repeat (5) advance();
        n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL flush_pre: got %0d expected 5", count); end
        flush = 1'b1;
        #1;
        n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL flush_grant: got %b expected 0000", req_grant); end
        advance();
        flush = 1'b0;
        n_checks++; if (count !== 5'd0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got count=%0d valid=%b expected 0/0", count, cmd_valid); end
        #1;
        n_checks++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL flush_regrant: got %b expected 0100", req_grant); end
        advance();
        req_valid = 4'b0000;
        n_checks++; if (count !== 5'd1 || cmd !== 4'd3) begin n_fail++; $display("FAIL flush_after: got count=%0d cmd=%0d expected 1/3", count, cmd); end
    endtask

    task automatic test_none_and_latency();
        do_reset();
        req_valid = 4'b0010;
        req_cmd   = 16'h0000;
        #1;
        n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL none_grant: got %b expected 0010", req_grant); end
        advance();
        n_checks++; if (count !== 5'd0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL none_count: got count=%0d valid=%b expected 0/0", count, cmd_valid); end
        req_cmd   = 16'h0040;
        cmd_ready = 1'b1;
        #1;
        n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL lat_grant: got %b expected 0010", req_grant); end
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL lat_bypass: got valid=%b expected 0", cmd_valid); end
        advance();
        req_valid = 4'b0000;
        n_checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd4 || count !== 5'd1) begin
            n_fail++; $display("FAIL lat_visible: got valid=%b cmd=%0d count=%0d expected 1/4/1", cmd_valid, cmd, count);
        end
        advance();
        n_checks++; if (count !== 5'd0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pop: got count=%0d valid=%b expected 0/0", count, cmd_valid); end
        cmd_ready = 1'b0;
    endtask

    task automatic test_all_req();
        int exp;
        do_reset();
        req_valid = 4'b1111;
        req_cmd   = 16'h4321;
        cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
`ifdef CMD_ARBITER_RR_EN
            exp = i % NREQ;
`else
            exp = 0;
`endif
            #1;
            n_checks++; if (req_grant !== 4'(1 << exp)) begin n_fail++; $display("FAIL seq_grant[%0d]: got %b expected index %0d", i, req_grant, exp); end
            advance();
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (req_grant !== 4'b0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL seq_reset: got grant=%b valid=%b expected 0000/0", req_grant, cmd_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        m_rr = 0;
        for (int i = 0; i < 2; i++) begin
`ifdef CMD_ARBITER_RR_EN
            exp = i;
`else
            exp = 0;
`endif
            #1;
            n_checks++; if (req_grant !== 4'(1 << exp)) begin n_fail++; $display("FAIL seq_restart[%0d]: got %b expected index %0d", i, req_grant, exp); end
            advance();
        end
        req_valid = 4'b0000;
        cmd_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        logic [3:0] prev_g;
        int         rate;
        do_reset();
        prev_g = '0;
        rate   = 50;
        for (int c = 0; c < 900; c++) begin
            if (c % 150 == 0) rate = (c / 150 % 3 == 0) ? 15 : ((c / 150 % 3 == 1) ? 90 : 50);
            reset_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || prev_g[i]) begin
                    req_valid[i]       = ($urandom_range(0, 2) != 0);
                    req_cmd[i*4 +: 4]  = 4'($urandom_range(0, 15));
                end
            end
            cmd_ready = ($urandom_range(0, 99) < rate);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            exp_g = model_grant();
            n_checks++; if (req_grant !== exp_g) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", c, req_grant, exp_g); end
            prev_g = exp_g;
            advance();
            n_checks++;
            if (cmd_valid !== (mq.size() != 0) || count !== 5'(mq.size()) || full !== (mq.size() == QSIZE) ||
                cmd !== ((mq.size() != 0) ? 4'(mq[0]) : 4'd0)) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: got valid=%b cmd=%0d count=%0d full=%b expected count=%0d head=%0d",
                         c, cmd_valid, cmd, count, full, mq.size(), (mq.size() != 0) ? mq[0] : 0);
            end
        end
        reset_n   = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        cmd_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        flush     = 1'b0;
        cmd_ready = 1'b0;
        m_rr      = 0;
        test_reset();
        test_fixed_priority();
        test_fill();
        test_flush();
        test_none_and_latency();
        test_all_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
